branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Control-side counterpart of the instruction-fetch program counter.
- Decodes the fetched instruction, holds the ALU condition flag, and looks up branch targets in a 32-entry writable LUT.
- Drives BranchAbs, BranchRelEn, Target and the flag to the fetch unit.
- Sequences program run/halt against the test bench Start/Done handshake.

Parameters:
- PC_W, 10, program counter / target width
- LUT_DEPTH, 32, number of branch target entries (index = Instr[4:0])
- CNT_W, 16, width of the run-cycle counter

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  test bench program request; held high to park, released to run
- Instr  in  9  current instruction, combinational from instruction memory at ProgCtr
- ProgCtr  in  PC_W  current PC from fetch unit
- AluFlag  in  1  condition result from ALU
- FlagWe  in  1  ALU instruction updates flag this cycle
- LutWe  in  1  target LUT write strobe
- LutAddr  in  5  LUT write index
- LutData  in  PC_W  LUT write data; absolute target, or two's-complement offset for relative branches
- BranchAbs  out  1  unconditional absolute jump to Target
- BranchRelEn  out  1  conditional relative jump; fetch unit qualifies it with ALU_flag
- ALU_flag  out  1  registered flag
- Target  out  PC_W  branch target or offset
- Done  out  1  program halted
- CycleCnt  out  CNT_W  cycles spent in RUN

Behaviour:
- Opcode is Instr[8:5]. Decoded values:
  - BRA = 4'hE: absolute branch, Target = LUT[Instr[4:0]].
  - BRZ = 4'hD: relative branch, Target = LUT[Instr[4:0]].
  - HALT = 9'h1FF.
  - All other encodings are non-branch.
- States: IDLE, RUN, HALT.
- Reset: state IDLE, flag 0, all LUT entries 0, CycleCnt 0, Done 0, BranchAbs 0, BranchRelEn 0, Target 0.
- Start=1 in any state: go to IDLE next cycle, clear CycleCnt, Done=0. Start has priority over every other event.
- IDLE with Start=0: go to RUN. The first RUN cycle decodes the instruction at the held PC.
- RUN:
  - Branch outputs are combinational from Instr and the LUT, so the fetch unit samples them at the same posedge. Zero added latency; no bubble.
  - BRA: BranchAbs=1, BranchRelEn=0.
  - BRZ: BranchRelEn=1, BranchAbs=0.
  - Other opcodes: both 0, Target=0.
- RUN, HALT decoded: go to HALT. In that same cycle drive BranchAbs=1 with Target=ProgCtr so the PC holds.
- HALT:
  - Done=1 (registered; rises the cycle after HALT is decoded).
  - BranchAbs=1 and Target=ProgCtr continuously, so the PC is frozen.
  - Stays in HALT until Start=1.
- IDLE: BranchAbs=BranchRelEn=0. The fetch unit holds the PC itself via Start.
- Flag register:
  - Loads AluFlag at posedge when FlagWe=1 and state is RUN. Ignored in IDLE and HALT.
  - BRZ uses the registered flag, i.e. the previous flag-writing instruction.
  - FlagWe in the same cycle as BRZ: the branch sees the old flag; the new value is visible next cycle.
- LUT:
  - Writes are accepted in any state.
  - Write and branch read of the same entry in one cycle: the branch gets the old value; the new value applies next cycle.
  - LutAddr is always in range (5 bits = 32 entries).
- Relative arithmetic is performed by the fetch unit as PC + Target, modulo 2^PC_W. Wrap-around is legal: offset 10'h3FF equals -1.
- CycleCnt:
  - Increments every cycle in RUN, including the cycle HALT is decoded.
  - Saturates at 2^CNT_W-1.
  - Holds in HALT; cleared by Reset or Start.
- Reset mid-run: everything, including the LUT, returns to reset values next cycle. The test bench must reload the LUT.

Decomposition:
- Package branch_ctrl_pkg holds:
  - opcode constants OP_BRA=4'hE, OP_BRZ=4'hD, INSTR_HALT=9'h1FF;
  - state enum {IDLE, RUN, HALT};
  - localparams for PC_W and LUT index width.
- Sub-module branch_lut: 32 x PC_W register file, one sync write port, one async read port, synchronous Reset clears all entries.
- FSM, flag register, decode and counter stay in branch_ctrl.

Test Plan:
- Reset, then Start 1->0, then Instr=9'h000 for 3 cycles -> state RUN, BranchAbs=BranchRelEn=0, CycleCnt=3.
- LUT[3]=10'h040, Instr=9'h1C3 (BRA idx 3) -> BranchAbs=1, Target=10'h040 in the same cycle; the PC reads 10'h040 next cycle.
- LUT[5]=10'h3FE (-2), FlagWe=1 with AluFlag=1, then next cycle Instr=9'h1A5 (BRZ) -> BranchRelEn=1, ALU_flag=1, Target=10'h3FE. Repeat with the FlagWe and BRZ in the same cycle -> ALU_flag=0 (old value).
- Instr=9'h1FF at ProgCtr=10'h07A -> BranchAbs=1, Target=10'h07A. Done=1 from the next cycle and stays; CycleCnt frozen; assert Start -> Done=0 and CycleCnt=0 next cycle.
- LutWe to entry 7 with 10'h100 while BRA idx 7 executes and LUT[7] holds 10'h080 -> Target=10'h080 this cycle, 10'h100 on the repeat.
- Reset asserted mid-RUN -> next cycle state IDLE, ALU_flag=0, LUT[3]=0, CycleCnt=0, all branch outputs 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch controller: opcodes, FSM states,
// default widths.
package branch_ctrl_pkg;

    localparam int PC_W_DFLT = 10;
    localparam int LUT_IDX_W = 5;

    localparam logic [3:0] OP_BRA     = 4'hE;
    localparam logic [3:0] OP_BRZ     = 4'hD;
    localparam logic [8:0] INSTR_HALT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Bus between the test-bench/fetch side and the branch controller.
// The master drives the program request, instruction, flag and LUT writes.
interface branch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [8:0]       Instr;
    logic [PC_W-1:0]  ProgCtr;
    logic             AluFlag;
    logic             FlagWe;
    logic             LutWe;
    logic [4:0]       LutAddr;
    logic [PC_W-1:0]  LutData;
    logic             BranchAbs;
    logic             BranchRelEn;
    logic             ALU_flag;
    logic [PC_W-1:0]  Target;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;

    modport master (
        output Start, Instr, ProgCtr, AluFlag, FlagWe, LutWe, LutAddr, LutData,
        input  BranchAbs, BranchRelEn, ALU_flag, Target, Done, CycleCnt
    );

    modport slave (
        input  Start, Instr, ProgCtr, AluFlag, FlagWe, LutWe, LutAddr, LutData,
        output BranchAbs, BranchRelEn, ALU_flag, Target, Done, CycleCnt
    );
endinterface

// File: rtl/branch_ctrl_lut.sv
// Branch target register file: one synchronous write port, one asynchronous
// read port; a read of an entry being written returns the old contents.
module branch_lut
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DFLT,
    parameter int DEPTH = 32,
    parameter int IDX_W = LUT_IDX_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [PC_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [PC_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: decodes the fetched instruction, holds the ALU flag,
// looks up branch targets and sequences run/halt against Start/Done.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W      = PC_W_DFLT,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input logic          Clk,
    input logic          Reset,
    branch_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic             flag_q, flag_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       opcode;
    logic             is_halt;
    logic [PC_W-1:0]  lut_rdata;
    logic             branch_abs;
    logic             branch_rel;
    logic [PC_W-1:0]  target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign opcode  = bus.Instr[8:5];
    assign is_halt = (bus.Instr == INSTR_HALT);

    branch_lut #(
        .PC_W  (PC_W),
        .DEPTH (LUT_DEPTH),
        .IDX_W (LUT_IDX_W)
    ) u_lut (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (bus.LutWe),
        .waddr (bus.LutAddr),
        .wdata (bus.LutData),
        .raddr (bus.Instr[4:0]),
        .rdata (lut_rdata)
    );

    // Branch outputs are combinational so fetch sees them at the same edge;
    // halting is an absolute jump onto the current PC.
    always_comb begin
        branch_abs = 1'b0;
        branch_rel = 1'b0;
        target     = '0;
        unique case (state_q)
            RUN: begin
                if (is_halt) begin
                    branch_abs = 1'b1;
                    target     = bus.ProgCtr;
                end else if (opcode == OP_BRA) begin
                    branch_abs = 1'b1;
                    target     = lut_rdata;
                end else if (opcode == OP_BRZ) begin
                    branch_rel = 1'b1;
                    target     = lut_rdata;
                end
            end
            HALT: begin
                branch_abs = 1'b1;
                target     = bus.ProgCtr;
            end
            default: ;
        endcase
    end

    // Start overrides every other event, including flag loads and HALT decode.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (bus.Start) begin
            state_d = IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    cnt_d = sat_inc(cnt_q);
                    if (bus.FlagWe) begin
                        flag_d = bus.AluFlag;
                    end
                    if (is_halt) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end
                end
                HALT: done_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.BranchAbs   = branch_abs;
    assign bus.BranchRelEn = branch_rel;
    assign bus.Target      = target;
    assign bus.ALU_flag    = flag_q;
    assign bus.Done        = done_q;
    assign bus.CycleCnt    = cnt_q;

endmodule
